// File: rtl/butterfly_pipe.sv
// Radix-2 complex butterfly with per-sample DIT/DIF and inverse selection, a
// 3-stage valid/ready pipeline, optional divide-by-2, rounding and saturation.
module butterfly_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int EXPAND     = 6,
    parameter int ROUND      = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in1_real,
    input  logic signed [DATA_WIDTH-1:0] in1_imag,
    input  logic signed [DATA_WIDTH-1:0] in2_real,
    input  logic signed [DATA_WIDTH-1:0] in2_imag,
    input  logic signed [EXPAND+1:0]     ro_real,
    input  logic signed [EXPAND+1:0]     ro_imag,
    input  logic                         mode_dif,
    input  logic                         inverse,
    input  logic                         scale,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH:0]   out1_real,
    output logic signed [DATA_WIDTH:0]   out1_imag,
    output logic signed [DATA_WIDTH:0]   out2_real,
    output logic signed [DATA_WIDTH:0]   out2_imag,
    input  logic                         clr_ovf,
    output logic                         ovf
);
    localparam int RW = DATA_WIDTH + 6;
    localparam int WW = EXPAND + 3;
    localparam int PW = RW + WW + 1;
    localparam int OW = DATA_WIDTH + 1;
    localparam logic signed [PW-1:0] RND_ADD = (ROUND != 0) ? PW'(64'd1 << (EXPAND - 1)) : '0;
    localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< DATA_WIDTH) - 64'sd1);
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

    // x1*w1 -/+ x2*w2 at full precision, then rounded shift back to data scale.
    function automatic logic signed [RW-1:0] mac_shift(
        input logic signed [RW-1:0] x1, input logic signed [WW-1:0] w1,
        input logic signed [RW-1:0] x2, input logic signed [WW-1:0] w2,
        input logic sub);
        logic signed [PW-1:0] x1e, x2e, w1e, w2e, acc;
        x1e = PW'(x1);
        x2e = PW'(x2);
        w1e = PW'(w1);
        w2e = PW'(w2);
        acc = sub ? (x1e * w1e - x2e * w2e) : (x1e * w1e + x2e * w2e);
        acc = (acc + RND_ADD) >>> EXPAND;
        return acc[RW-1:0];
    endfunction

    function automatic logic signed [RW-1:0] scale_fn(input logic signed [RW-1:0] x, input logic sc);
        return sc ? ((x + RW'(ROUND)) >>> 1) : x;
    endfunction

    function automatic logic clamps(input logic signed [RW-1:0] x);
        return (x > SAT_MAX) || (x < SAT_MIN);
    endfunction

    function automatic logic signed [OW-1:0] sat_fn(input logic signed [RW-1:0] x);
        logic signed [RW-1:0] y;
        y = (x > SAT_MAX) ? SAT_MAX : ((x < SAT_MIN) ? SAT_MIN : x);
        return y[OW-1:0];
    endfunction

    logic ce;
    logic vld_p1_q, vld_p2_q, out_valid_q, ovf_q;
    logic dif_p1_q, sc_p1_q, sc_p2_q;
    logic signed [WW-1:0] w_re_p1_q, w_im_p1_q;
    logic signed [RW-1:0] u_re_p1_q, u_im_p1_q, v_re_p1_q, v_im_p1_q;
    logic signed [RW-1:0] u_re_p1_d, u_im_p1_d, v_re_p1_d, v_im_p1_d;
    logic signed [RW-1:0] o1_re_p2_q, o1_im_p2_q, o2_re_p2_q, o2_im_p2_q;
    logic signed [RW-1:0] o1_re_p2_d, o1_im_p2_d, o2_re_p2_d, o2_im_p2_d;
    logic signed [RW-1:0] a_re, a_im, b_re, b_im, s1_re, s1_im, s2_re, s2_im;
    logic signed [WW-1:0] w_re, w_im;
    logic signed [OW-1:0] out1_re_q, out1_im_q, out2_re_q, out2_im_q;
    logic                 clamp_any;

    assign ce       = !out_valid_q || out_ready;
    assign in_ready = ce;

    // ---- stage 1: DIT twiddle product of b, or DIF sum/difference ----
    always_comb begin
        a_re = RW'(in1_real);
        a_im = RW'(in1_imag);
        b_re = RW'(in2_real);
        b_im = RW'(in2_imag);
        w_re = WW'(ro_real);
        w_im = inverse ? -WW'(ro_imag) : WW'(ro_imag);
        if (mode_dif) begin
            u_re_p1_d = a_re + b_re;
            u_im_p1_d = a_im + b_im;
            v_re_p1_d = a_re - b_re;
            v_im_p1_d = a_im - b_im;
        end else begin
            u_re_p1_d = a_re;
            u_im_p1_d = a_im;
            v_re_p1_d = mac_shift(b_re, w_re, b_im, w_im, 1'b1);
            v_im_p1_d = mac_shift(b_re, w_im, b_im, w_re, 1'b0);
        end
    end

    // ---- stage 2: DIT add/subtract, or DIF twiddle product of the difference ----
    always_comb begin
        if (dif_p1_q) begin
            o1_re_p2_d = u_re_p1_q;
            o1_im_p2_d = u_im_p1_q;
            o2_re_p2_d = mac_shift(v_re_p1_q, w_re_p1_q, v_im_p1_q, w_im_p1_q, 1'b1);
            o2_im_p2_d = mac_shift(v_re_p1_q, w_im_p1_q, v_im_p1_q, w_re_p1_q, 1'b0);
        end else begin
            o1_re_p2_d = u_re_p1_q + v_re_p1_q;
            o1_im_p2_d = u_im_p1_q + v_im_p1_q;
            o2_re_p2_d = u_re_p1_q - v_re_p1_q;
            o2_im_p2_d = u_im_p1_q - v_im_p1_q;
        end
    end

    // ---- stage 3: optional halving, then clamp to the output range ----
    always_comb begin
        s1_re = scale_fn(o1_re_p2_q, sc_p2_q);
        s1_im = scale_fn(o1_im_p2_q, sc_p2_q);
        s2_re = scale_fn(o2_re_p2_q, sc_p2_q);
        s2_im = scale_fn(o2_im_p2_q, sc_p2_q);
        clamp_any = clamps(s1_re) || clamps(s1_im) || clamps(s2_re) || clamps(s2_im);
    end

    always_ff @(posedge clk) begin
        if (ce && in_valid) begin
            u_re_p1_q <= u_re_p1_d;
            u_im_p1_q <= u_im_p1_d;
            v_re_p1_q <= v_re_p1_d;
            v_im_p1_q <= v_im_p1_d;
            w_re_p1_q <= w_re;
            w_im_p1_q <= w_im;
            dif_p1_q  <= mode_dif;
            sc_p1_q   <= scale;
        end
        if (ce && vld_p1_q) begin
            o1_re_p2_q <= o1_re_p2_d;
            o1_im_p2_q <= o1_im_p2_d;
            o2_re_p2_q <= o2_re_p2_d;
            o2_im_p2_q <= o2_im_p2_d;
            sc_p2_q    <= sc_p1_q;
        end
    end

    // Valids, flag and visible outputs reset; a sticky set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            out1_re_q   <= '0;
            out1_im_q   <= '0;
            out2_re_q   <= '0;
            out2_im_q   <= '0;
        end else begin
            ovf_q <= (ovf_q && !clr_ovf) || (ce && vld_p2_q && clamp_any);
            if (ce) begin
                vld_p1_q    <= in_valid;
                vld_p2_q    <= vld_p1_q;
                out_valid_q <= vld_p2_q;
                if (vld_p2_q) begin
                    out1_re_q <= sat_fn(s1_re);
                    out1_im_q <= sat_fn(s1_im);
                    out2_re_q <= sat_fn(s2_re);
                    out2_im_q <= sat_fn(s2_im);
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign out1_real = out1_re_q;
    assign out1_imag = out1_im_q;
    assign out2_real = out2_re_q;
    assign out2_imag = out2_im_q;
endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed bench for butterfly_pipe: a rounding and a truncating instance share
// stimulus; an arithmetic model plus scoreboard checks every output cycle.
`timescale 1ns/1ps
module tb_butterfly_pipe;
    localparam int DW   = 8;
    localparam int E    = 6;
    localparam int WTW  = E + 2;
    localparam longint MAXV = (longint'(1) << DW) - 1;
    localparam longint MINV = -(longint'(1) << DW);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, in_valid, mode_dif, inverse, scale, out_ready, clr_ovf;
    logic in_ready, out_valid, ovf, in_ready_t, out_valid_t, ovf_t;
    logic signed [DW-1:0] in1_real, in1_imag, in2_real, in2_imag;
    logic signed [WTW-1:0] ro_real, ro_imag;
    logic signed [DW:0] out1_real, out1_imag, out2_real, out2_imag;
    logic signed [DW:0] t1_real, t1_imag, t2_real, t2_imag;

    butterfly_pipe #(.DATA_WIDTH(DW), .EXPAND(E), .ROUND(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1_real(in1_real), .in1_imag(in1_imag), .in2_real(in2_real), .in2_imag(in2_imag),
        .ro_real(ro_real), .ro_imag(ro_imag), .mode_dif(mode_dif), .inverse(inverse),
        .scale(scale), .out_valid(out_valid), .out_ready(out_ready),
        .out1_real(out1_real), .out1_imag(out1_imag), .out2_real(out2_real),
        .out2_imag(out2_imag), .clr_ovf(clr_ovf), .ovf(ovf));

    butterfly_pipe #(.DATA_WIDTH(DW), .EXPAND(E), .ROUND(0)) u_trunc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .in1_real(in1_real), .in1_imag(in1_imag), .in2_real(in2_real), .in2_imag(in2_imag),
        .ro_real(ro_real), .ro_imag(ro_imag), .mode_dif(mode_dif), .inverse(inverse),
        .scale(scale), .out_valid(out_valid_t), .out_ready(out_ready),
        .out1_real(t1_real), .out1_imag(t1_imag), .out2_real(t2_real),
        .out2_imag(t2_imag), .clr_ovf(clr_ovf), .ovf(ovf_t));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        longint v[4];
        bit     clamp;
        int     t;
    } exp_t;

    function automatic longint rs(input longint x, input int rnd);
        return (x + ((rnd != 0) ? (longint'(1) << (E - 1)) : longint'(0))) >>> E;
    endfunction

    function automatic exp_t model(input longint ar, input longint ai, input longint br,
                                   input longint bi, input longint wr, input longint wi0,
                                   input bit dif, input bit inv, input bit sc, input int rnd);
        exp_t e;
        longint wi, pr, pi, dr, di;
        longint r[4];
        wi = inv ? -wi0 : wi0;
        if (!dif) begin
            pr = rs(br * wr - bi * wi, rnd);
            pi = rs(br * wi + bi * wr, rnd);
            r[0] = ar + pr; r[1] = ai + pi; r[2] = ar - pr; r[3] = ai - pi;
        end else begin
            dr = ar - br; di = ai - bi;
            r[0] = ar + br; r[1] = ai + bi;
            r[2] = rs(dr * wr - di * wi, rnd);
            r[3] = rs(dr * wi + di * wr, rnd);
        end
        e.clamp = 1'b0;
        e.t = 0;
        for (int k = 0; k < 4; k++) begin
            if (sc) r[k] = (r[k] + longint'(rnd)) >>> 1;
            if (r[k] > MAXV) begin r[k] = MAXV; e.clamp = 1'b1; end
            else if (r[k] < MINV) begin r[k] = MINV; e.clamp = 1'b1; end
            e.v[k] = r[k];
        end
        return e;
    endfunction

    // Scoreboard and per-cycle compare, sampled on the falling edge.
    exp_t q1[$];
    exp_t q0[$];
    exp_t e1, e0;
    bit shown = 1'b0;
    bit ovf_e1 = 1'b0, ovf_e0 = 1'b0, clr_prev = 1'b0;
    int ecount = 0;
    int delivered = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            q0.delete();
            shown = 1'b0; ovf_e1 = 1'b0; ovf_e0 = 1'b0; clr_prev = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_out1_real", out1_real, 0);
            chk("rst_out2_imag", out2_imag, 0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            bit nclamp1, nclamp0;
            nclamp1 = 1'b0;
            nclamp0 = 1'b0;
            chk("in_ready_rule", in_ready, (!out_valid || out_ready));
            chk("trunc_out_valid", out_valid_t, out_valid);
            if (out_valid) begin
                if (q1.size() == 0) begin
                    chk("stale_output", 1, 0);
                end else begin
                    if (!shown) begin
                        shown = 1'b1;
                        nclamp1 = q1[0].clamp;
                        nclamp0 = q0[0].clamp;
                        chk("latency", ecount - q1[0].t, 3);
                    end
                    chk("out1_real", out1_real, q1[0].v[0]);
                    chk("out1_imag", out1_imag, q1[0].v[1]);
                    chk("out2_real", out2_real, q1[0].v[2]);
                    chk("out2_imag", out2_imag, q1[0].v[3]);
                    chk("trunc_out1_real", t1_real, q0[0].v[0]);
                    chk("trunc_out1_imag", t1_imag, q0[0].v[1]);
                    chk("trunc_out2_real", t2_real, q0[0].v[2]);
                    chk("trunc_out2_imag", t2_imag, q0[0].v[3]);
                end
            end
            ovf_e1 = (ovf_e1 && !clr_prev) || nclamp1;
            ovf_e0 = (ovf_e0 && !clr_prev) || nclamp0;
            chk("ovf", ovf, ovf_e1);
            chk("trunc_ovf", ovf_t, ovf_e0);
            if (out_valid && out_ready && q1.size() > 0) begin
                void'(q1.pop_front());
                void'(q0.pop_front());
                shown = 1'b0;
                delivered++;
            end
            if (in_valid && in_ready) begin
                e1 = model(in1_real, in1_imag, in2_real, in2_imag, ro_real, ro_imag,
                           mode_dif, inverse, scale, 1);
                e0 = model(in1_real, in1_imag, in2_real, in2_imag, ro_real, ro_imag,
                           mode_dif, inverse, scale, 0);
                e1.t = ecount;
                e0.t = ecount;
                q1.push_back(e1);
                q0.push_back(e0);
            end
            if (in_ready) ecount++;
            clr_prev = clr_ovf;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi, input bit dif, input bit inv, input bit sc);
        int n;
        n = 0;
        in1_real = DW'(ar); in1_imag = DW'(ai);
        in2_real = DW'(br); in2_imag = DW'(bi);
        ro_real = WTW'(wr); ro_imag = WTW'(wi);
        mode_dif = dif; inverse = inv; scale = sc;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 60);
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic lit(input string n, input longint a, input longint b, input longint c, input longint d);
        chk({n, "_o1r"}, out1_real, a);
        chk({n, "_o1i"}, out1_imag, b);
        chk({n, "_o2r"}, out2_real, c);
        chk({n, "_o2i"}, out2_imag, d);
    endtask

    task automatic lit_t(input string n, input longint a, input longint b, input longint c, input longint d);
        chk({n, "_o1r"}, t1_real, a);
        chk({n, "_o1i"}, t1_imag, b);
        chk({n, "_o2r"}, t2_real, c);
        chk({n, "_o2i"}, t2_imag, d);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t m;
        int d0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
        in1_real = '0; in1_imag = '0; in2_real = '0; in2_imag = '0;
        ro_real = '0; ro_imag = '0; mode_dif = 1'b0; inverse = 1'b0; scale = 1'b0;

        // Pin the model against hand-computed values.
        m = model(10, -5, 3, 7, 0, -64, 1'b0, 1'b1, 1'b0, 1);
        chk("model_inv_o1r", m.v[0], 3);
        chk("model_inv_o2r", m.v[2], 17);
        m = model(10, -5, 3, 7, 0, -64, 1'b1, 1'b0, 1'b0, 1);
        chk("model_dif_o2r", m.v[2], -12);
        chk("model_dif_o2i", m.v[3], -7);
        m = model(127, 127, 127, 127, 64, 64, 1'b0, 1'b0, 1'b0, 1);
        chk("model_sat_o1i", m.v[1], 255);
        chk("model_sat_clamp", longint'(m.clamp), 1);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // DIT identity twiddle and latency
        send(10, -5, 3, 7, 64, 0, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("t1_not_yet_valid", out_valid, 0);
        idle(1);
        chk("t1_valid_third_cycle", out_valid, 1);
        lit("t1", 13, 2, 7, -12);
        idle(3);

        // DIT with -j twiddle, then its conjugate
        send(10, -5, 3, 7, 0, -64, 1'b0, 1'b0, 1'b0);
        idle(4);
        lit("t2", 17, -8, 3, -2);
        send(10, -5, 3, 7, 0, -64, 1'b0, 1'b1, 1'b0);
        idle(4);
        lit("t2_inv", 3, -2, 17, -8);

        // DIF, then DIT with halving
        send(10, -5, 3, 7, 0, -64, 1'b1, 1'b0, 1'b0);
        idle(4);
        lit("t3_dif", 13, 2, -12, -7);
        send(10, -5, 3, 7, 64, 0, 1'b0, 1'b0, 1'b1);
        idle(4);
        lit("t3_scale", 7, 1, 4, -6);

        // Half-LSB product: rounds up in one build, truncates in the other
        send(0, 0, 1, 0, 32, 0, 1'b0, 1'b0, 1'b0);
        idle(4);
        lit("t4_round", 1, 0, -1, 0);
        lit_t("t4_trunc", 0, 0, 0, 0);

        // Saturation, sticky flag, set beating clear
        send(127, 127, 127, 127, 64, 64, 1'b0, 1'b0, 1'b0);
        idle(4);
        lit("t5_sat", 127, 255, 127, -127);
        chk("t5_ovf_set", ovf, 1);
        send(127, 127, 127, 127, 64, 64, 1'b0, 1'b0, 1'b0);
        idle(1);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        chk("t5_set_wins", ovf, 1);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        chk("t5_cleared", ovf, 0);
        idle(3);

        // Backpressure: five back-to-back samples into a stalled output
        d0 = delivered;
        out_ready = 1'b0;
        fork
            begin
                send(10, -5, 3, 7, 64, 0, 1'b0, 1'b0, 1'b0);
                send(-20, 15, 9, -4, 45, -30, 1'b0, 1'b1, 1'b0);
                send(50, -60, -40, 33, -64, 20, 1'b1, 1'b0, 1'b1);
                send(-128, 100, 127, -1, 17, -128, 1'b1, 1'b1, 1'b0);
                send(100, -100, -100, 100, 64, 0, 1'b0, 1'b0, 1'b1);
            end
            begin
                idle(8);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                lit("bp_hold", 13, 2, 7, -12);
                out_ready = 1'b1;
            end
        join
        idle(8);
        chk("bp_delivered", delivered - d0, 5);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;

        // Reset with two samples in flight, one already on the output
        out_ready = 1'b0;
        send(5, 6, 7, 8, 64, 0, 1'b0, 1'b0, 1'b0);
        send(-3, 2, 1, -9, 0, 64, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("rst_pre_valid", out_valid, 1);
        d0 = delivered;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_out1r", out1_real, 0);
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(8);
        chk("rst_no_stale", delivered - d0, 0);
        chk("rst_final_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Next-generation radix-2 complex butterfly for the FFT datapath, replacing the fixed DIT en/valid butterfly.
- Adds per-sample DIT/DIF mode, inverse (conjugate-twiddle) mode, optional divide-by-2 stage scaling, rounding and saturation.
- Uses a 3-stage pipeline with valid/ready backpressure, and sits between the stage memory read port and write-back.

Parameters:
- DATA_WIDTH, 8, signed width of each input component.
- EXPAND, 6, twiddle fixed-point shift; twiddle 1.0 = 1<<EXPAND; twiddle width = EXPAND+2.
- ROUND, 1, 1 = round half-up on every right shift; 0 = truncate (arithmetic shift).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts input this cycle.
- in1_real, in1_imag  in  DATA_WIDTH  operand a, signed.
- in2_real, in2_imag  in  DATA_WIDTH  operand b, signed.
- ro_real, ro_imag  in  EXPAND+2  twiddle W, signed.
- mode_dif  in  1  0 = DIT, 1 = DIF; sampled with the input.
- inverse  in  1  1 = use conj(W); sampled with the input.
- scale  in  1  1 = outputs divided by 2; sampled with the input.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts output.
- out1_real, out1_imag, out2_real, out2_imag  out  DATA_WIDTH+1  results, signed.
- clr_ovf  in  1  synchronous clear of ovf.
- ovf  out  1  sticky saturation flag.

Behaviour:
- Reset is asynchronous and active-low. On reset: all stage valids, out_valid and ovf are 0; all out*_real/imag are 0. in_ready = 1 after reset.
- Reset mid-operation discards all in-flight samples. No output appears for them after reset is released.
- Handshake:
  - Global pipeline enable: ce = !out_valid || out_ready.
  - in_ready = ce (combinational).
  - An input is accepted when in_valid && in_ready.
  - An output transfers when out_valid && out_ready.
  - While ce = 0, all stages and outputs hold stable.
  - Bubbles advance with ce; they are not collapsed.
- Latency: an accepted sample appears on outputs exactly 3 enabled cycles later. Throughput is 1 sample/cycle when out_ready = 1. Order is preserved.
- Twiddle: Weff = inverse ? (ro_real, -ro_imag) : (ro_real, ro_imag). Negation is done at EXPAND+3 bits, so -(-2^(EXPAND+1)) is exact.
- Complex multiply of X by Weff:
  - Re = Xr*Wr - Xi*Wi; Im = Xr*Wi + Xi*Wr, at full precision.
  - Then shift right by EXPAND. With ROUND = 1, add 1<<(EXPAND-1) before the shift.
- Stage order:
  - DIT: S1 computes P = b*Weff. S2 computes out1 = a+P, out2 = a-P.
  - DIF: S1 computes D = a-b and S = a+b. S2 computes out2 = D*Weff, out1 = S.
  - S3 (both modes): optional scale and saturate.
  - mode_dif, inverse and scale travel with the data through the pipeline.
- Scale: when scale = 1, each result becomes (x + ROUND) >>> 1 (arithmetic shift), applied before saturation.
- Width and saturation:
  - All internal sums are kept at full width.
  - Final values clamp to [-2^DATA_WIDTH, 2^DATA_WIDTH - 1].
  - Any clamp on a transferred-into-S3 sample sets ovf.
- ovf stays set until clr_ovf or reset. If set and clr_ovf happen in the same cycle, set wins (ovf = 1).

Test Plan:
1. DIT, W=(64,0), a=(10,-5), b=(3,7), scale=0 -> out1=(13,2), out2=(7,-12), out_valid 3 cycles after acceptance.
2. DIT, W=(0,-64), same a/b -> out1=(17,-8), out2=(3,-2). Same inputs with inverse=1 -> out1=(3,-2), out2=(17,-8).
3. DIF, W=(0,-64), same a/b -> out1=(13,2), out2=(-12,-7). Then DIT with scale=1, W=(64,0) -> out1=(7,1), out2=(4,-6).
4. Rounding: a=(0,0), b=(1,0), W=(32,0), DIT. ROUND=1 -> out1=(1,0), out2=(-1,0). ROUND=0 build -> both (0,0).
5. Saturation: a=(127,127), b=(127,127), W=(64,64), DIT -> out1=(127,255), ovf=1, out2=(127,-127). clr_ovf together with another saturating sample -> ovf stays 1.
6. Backpressure and reset:
   - Stream 5 back-to-back samples with out_ready=0 -> in_ready drops once the first result reaches the output.
   - Outputs hold stable; release -> 5 results in order, none lost or duplicated.
   - Assert rst_n low with 2 samples in flight -> out_valid=0 immediately; no stale output after release.
